uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Buffered UART receive front end, the consumer-side counterpart of the team's byte transmitter: it accepts 8N1 serial frames (8 data bits, no parity, 1 stop bit) on `uart_rx` and samples each bit at mid-bit. It rejects glitch start bits, flags framing errors and queues good bytes in a first-word-fall-through FIFO. It sits between the board's RX pin and the processor's I/O logic, so the core can drain bytes at its own pace without losing back-to-back frames.

## Interface
- `CLK_CYCLES`, 4167: clock cycles per bit period; minimum 4.
- `CTR_WIDTH`, 16: bit-timer width; must hold `CLK_CYCLES-1`.
- `DEPTH_LOG2`, 4: FIFO depth is 2**DEPTH_LOG2 entries.

Ports:
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active low.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `data`  out  8  FIFO head byte; valid only while `valid`=1.
- `valid`  out  1  FIFO non-empty.
- `pop`  in  1  consume head; ignored when `valid`=0.
- `count`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `framing_err`  out  1  one-cycle pulse on bad stop bit.
- `overrun`  out  1  sticky: good byte dropped because the FIFO was full; cleared only by reset.

## Operation
- Reset values:
  - Synchronizer flops = 1; state = IDLE; FIFO pointers and `count` = 0.
  - `valid` = 0, `framing_err` = 0, `overrun` = 0; `data` = 0.
- `uart_rx` passes through a 2-flop synchronizer; the FSM uses only the synchronized value `rxs`.
- IDLE: on `rxs`=0, load timer with `CLK_CYCLES/2 - 1` (integer divide) and go to START.
- The timer counts down to 0. In every bit state, the `rxs` sample is taken in the cycle the timer reads 0. After each sample, the timer reloads with `CLK_CYCLES-1`.
- START: sample = 1 means a false start; return to IDLE with no flag. Sample = 0 goes to DATA with bit index 0.
- DATA: shift the sample into the shift register LSB first. After index 7, go to STOP.
- STOP, sample = 1:
  - FIFO not full: push the byte.
  - FIFO full: drop the byte and set `overrun`.
  - Either way, return to IDLE.
- STOP, sample = 0:
  - Discard the byte and pulse `framing_err`.
  - Go to WAIT_HIGH, which stays there until `rxs`=1, then returns to IDLE. This prevents a break condition from generating repeated frames.
- FIFO:
  - Read and write pointers are DEPTH_LOG2+1 bits; wrap-around is natural.
  - Full = pointer MSBs differ and the remaining bits are equal. Empty = pointers equal.
  - Memory is registered; `data` = mem[rd_ptr] read combinationally (fall-through).
- Push and pop in the same cycle:
  - Both are always accepted, including when full; `count` is unchanged.
  - A push that arrives while the FIFO is full with no pop in that cycle is an overrun.
- Pop when empty: no effect; pointers and `count` do not change.
- Reset asserted mid-frame: the frame is abandoned, the FIFO is emptied, and every output returns to its reset value immediately.

## Timing
- Synchronizer latency: 2 cycles from the `uart_rx` edge to `rxs`.
- Let t = the cycle in which IDLE sees `rxs`=0.
  - Start sample: t + CLK_CYCLES/2.
  - Data bit k sample: t + CLK_CYCLES/2 + (k+1)·CLK_CYCLES.
  - Stop sample: t + CLK_CYCLES/2 + 9·CLK_CYCLES.
- Push occurs on the edge ending the stop-sample cycle; `valid` and `count` update on that same edge, i.e. visible 1 cycle after the stop sample.
- `framing_err` is high for exactly the cycle after the stop sample.
- Pop: `data`, `count` and `valid` reflect the new head on the edge where `pop`=1 && `valid`=1.
- After a good stop bit, IDLE is re-entered immediately. A start bit beginning right after the stop-sample cycle is accepted, so no receive gap is required between frames.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1; the DATA state is followed by a PARITY state, and the stop sample moves to t + CLK_CYCLES/2 + 10·CLK_CYCLES.
  - Output `parity_err` (1 bit, reset 0) is added as a one-cycle pulse aligned like `framing_err`.
  - A byte with a parity mismatch and a good stop bit is discarded, not pushed.
- Undefined: 8N1 only; the PARITY state and `parity_err` port do not exist.

## Test plan
All scenarios use CLK_CYCLES=16, DEPTH_LOG2=2.
- Send 0xA5 as an 8N1 frame -> `valid` rises 1 cycle after the stop sample; `data`=0xA5; `count`=1; pulse `pop` -> `valid`=0, `count`=0.
- Drive `uart_rx` low for 4 cycles, then high -> no push, no `framing_err`, FSM back in IDLE; a following frame 0x3C is received correctly.
- Send 0x55 with the stop bit held low, line low for 40 more cycles -> single `framing_err` pulse, `count`=0; after the line goes high, frame 0x0F is received.
- Send 5 frames (0x01..0x05) back to back without popping -> `count`=4, `overrun`=1; pops return 0x01..0x04 in order.
- Pop every cycle while frames arrive, including `pop` asserted while `valid`=0 -> no underflow; all bytes come out in order; `count` never exceeds 1.
- Assert `rst_n`=0 during bit 3 of a frame with 2 bytes queued -> `valid`=0, `count`=0, `overrun`=0 immediately; after release, a new frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: 8N1 UART receiver (mid-bit sampling, glitch/framing checks) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err pulse output.
module uart_rx_fifo #(
   parameter int CLK_CYCLES = 4167,
   parameter int CTR_WIDTH  = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  uart_rx,
   output logic [7:0]            data,
   output logic                  valid,
   input  logic                  pop,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  framing_err,
`ifdef UART_RX_PARITY_EN
   output logic                  parity_err,
`endif
   output logic                  overrun
);
   localparam logic [CTR_WIDTH-1:0] HALF = CTR_WIDTH'(CLK_CYCLES / 2 - 1);
   localparam logic [CTR_WIDTH-1:0] FULL = CTR_WIDTH'(CLK_CYCLES - 1);
   typedef enum logic [2:0] {
      IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP, WAIT_HIGH
   } state_t;
   state_t state, state_n;
   logic [1:0] sync;
   logic rxs, tick, push, ferr_n;
   logic [CTR_WIDTH-1:0] timer, timer_n;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n;
`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_n, perr_n;
`endif
   logic [7:0] mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wr, rd;
   logic full, do_pop, do_push;
   assign rxs = sync[1];
   assign tick = timer == '0;
   // next-state, bit timer and shift register; a sample is taken whenever the timer reads 0
   always_comb begin
      state_n = state;
      timer_n = tick ? FULL : timer - 1'b1;
      idx_n = idx;
      sh_n = sh;
      push = 1'b0;
      ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      perr_n = 1'b0;
`endif
      case (state)
         IDLE: if (!rxs) begin
            state_n = START;
            timer_n = HALF;
         end
         START: if (tick) begin
            state_n = rxs ? IDLE : DATA;
            idx_n = '0;
         end
         DATA: if (tick) begin
            sh_n = {rxs, sh[7:1]};
            idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state_n = PARITY;
`else
            if (idx == 3'd7) state_n = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            par_bad_n = rxs != ^sh;
            state_n = STOP;
         end
`endif
         STOP: if (tick) begin
            state_n = rxs ? IDLE : WAIT_HIGH;
            ferr_n = !rxs;
`ifdef UART_RX_PARITY_EN
            push = rxs && !par_bad;
            perr_n = par_bad;
`else
            push = rxs;
`endif
         end
         WAIT_HIGH: if (rxs) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // synchronizer and receiver state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         state <= IDLE;
         timer <= '0;
         idx <= '0;
         sh <= '0;
         framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync <= {sync[0], uart_rx};
         state <= state_n;
         timer <= timer_n;
         idx <= idx_n;
         sh <= sh_n;
         framing_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_n;
         parity_err <= perr_n;
`endif
      end
   end
   assign full = (wr ^ rd) == {1'b1, {DEPTH_LOG2{1'b0}}};
   assign valid = wr != rd;
   assign count = wr - rd;
   assign do_pop = pop && valid;
   assign do_push = push && (!full || do_pop);
   assign data = valid ? mem[rd[DEPTH_LOG2-1:0]] : '0;
   // FIFO storage; contents need no reset because data is masked while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr[DEPTH_LOG2-1:0]] <= sh;
   end
   // FIFO pointers and sticky overrun flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
         if (push && full && !do_pop) overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: directed frames with a scoreboard queue of expected bytes drained by a monitor.
module tb_uart_rx_fifo;
   localparam int CC = 16;
   localparam int DL = 2;
   logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, pop = 1'b0;
   logic [7:0] data;
   logic valid, framing_err, overrun;
   logic [DL:0] count;
   int n_checks = 0, n_pass = 0, ferr_cnt = 0, max_count = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_CYCLES(CC), .CTR_WIDTH(16), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .data(data), .valid(valid),
      .pop(pop), .count(count), .framing_err(framing_err), .overrun(overrun)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drives the first nbits of {stop, b, start}; caller is aligned just after a posedge.
   task automatic send(input logic [7:0] b, input logic stop, input int nbits, input bit expect_byte);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      if (expect_byte) exp_q.push_back(b);
      for (int i = 0; i < nbits; i++) begin
         #1 uart_rx = f[i];
         repeat (CC) @(posedge clk);
      end
   endtask

   // monitor: every byte consumed by pop is checked against the scoreboard head
   always @(negedge clk) begin
      if (rst_n) begin
         if (framing_err) ferr_cnt++;
         if (int'(count) > max_count) max_count = int'(count);
         if (valid && pop) begin
            if (exp_q.size() == 0) chk("unexpected_byte", int'(data), 256);
            else chk("rx_byte", int'(data), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_framing_err", int'(framing_err), 0);
      chk("rst_data", int'(data), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      // frame 0xA5: valid rises exactly one cycle after the stop sample
      fork
         send(8'hA5, 1'b1, 10, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 chk("a5_valid_before", int'(valid), 0);
            @(posedge clk);
            #1 chk("a5_valid_rise", int'(valid), 1);
            chk("a5_count", int'(count), 1);
            chk("a5_data", int'(data), 8'hA5);
            pop = 1'b1;
            repeat (2) @(posedge clk);
            #1 chk("a5_valid_after_pop", int'(valid), 0);
            chk("a5_count_after_pop", int'(count), 0);
         end
      join
      // 4-cycle glitch is a false start
      #1 uart_rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (40) @(posedge clk);
      chk("glitch_count", int'(count), 0);
      chk("glitch_ferr", ferr_cnt, 0);
      send(8'h3C, 1'b1, 10, 1'b1);
      repeat (4) @(posedge clk);
      chk("3c_drained", exp_q.size(), 0);
      // bad stop bit followed by a held-low line gives a single framing error
      ferr_cnt = 0;
      send(8'h55, 1'b0, 10, 1'b0);
      repeat (40) @(posedge clk);
      chk("ferr_pulses", ferr_cnt, 1);
      chk("ferr_count", int'(count), 0);
      #1 uart_rx = 1'b1;
      repeat (5) @(posedge clk);
      send(8'h0F, 1'b1, 10, 1'b1);
      repeat (4) @(posedge clk);
      chk("0f_drained", exp_q.size(), 0);
      chk("ferr_pulses_final", ferr_cnt, 1);
      // five frames into a four-entry FIFO: fifth is dropped with overrun
      #1 pop = 1'b0;
      @(posedge clk);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 10, i <= 4);
      repeat (4) @(posedge clk);
      chk("ovr_count", int'(count), 4);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_head", int'(data), 8'h01);
      #1 pop = 1'b1;
      repeat (8) @(posedge clk);
      chk("ovr_drained_count", int'(count), 0);
      chk("ovr_drained_q", exp_q.size(), 0);
      // continuous pop, including while empty
      max_count = 0;
      send(8'h11, 1'b1, 10, 1'b1);
      send(8'h22, 1'b1, 10, 1'b1);
      send(8'h33, 1'b1, 10, 1'b1);
      repeat (4) @(posedge clk);
      chk("pop_max_count", max_count, 1);
      chk("pop_drained_q", exp_q.size(), 0);
      chk("pop_count", int'(count), 0);
      chk("pop_valid", int'(valid), 0);
      chk("overrun_sticky", int'(overrun), 1);
      // reset during bit 3 of a frame with two bytes queued
      #1 pop = 1'b0;
      @(posedge clk);
      send(8'h61, 1'b1, 10, 1'b0);
      send(8'h62, 1'b1, 10, 1'b0);
      repeat (4) @(posedge clk);
      chk("pre_rst_count", int'(count), 2);
      send(8'hF0, 1'b1, 4, 1'b0);
      #1 uart_rx = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_valid", int'(valid), 0);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_overrun", int'(overrun), 0);
      chk("mid_rst_data", int'(data), 0);
      uart_rx = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      pop = 1'b1;
      repeat (5) @(posedge clk);
      send(8'h81, 1'b1, 10, 1'b1);
      repeat (4) @(posedge clk);
      chk("81_drained", exp_q.size(), 0);
      chk("final_valid", int'(valid), 0);
      chk("final_overrun", int'(overrun), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
